ingress: RTL and testbench
==========================

INGRESS -- requirements
Module: ingress

Interface
REQ-001 Parameter PACKET_XFER_LEN, default 32: width of every packet word.
REQ-002 Parameter DESC_DEPTH, default 16: descriptor FIFO depth (power of two).
REQ-003 Parameter SRC_PORT, default 1: 8-bit source port stamped into each packet.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 write_en  input  1  software enqueues a descriptor this cycle.
REQ-007 data_in  input  PACKET_XFER_LEN  descriptor {len[31:24] bytes, 8'b0, dest[15:8], 8'b0}.
REQ-008 counter  input  32  global time.
REQ-009 grant  input  1  scheduler grant for the head packet.
REQ-010 req_valid  output  1  head descriptor pending.
REQ-011 req_dest  output  8  dest field of head descriptor.
REQ-012 data_out  output  PACKET_XFER_LEN  packet word toward crossbar.
REQ-013 data_valid  output  1  data_out valid this cycle.
REQ-014 data_last  output  1  final word of packet.
REQ-015 buffer_empty / buffer_full  output  1 each  descriptor FIFO status.
REQ-016 drop_count  output  16  saturating count of rejected writes.

Function
REQ-017 On write_en with FIFO not full, store {len, dest, counter}; start_time = counter in the write cycle.
REQ-018 On write_en with FIFO full and no pop in the same cycle, discard the write; drop_count increments, saturating at 16'hFFFF.
REQ-019 On write_en with FIFO full and a pop in the same cycle, accept the write; occupancy stays unchanged.
REQ-020 buffer_full/buffer_empty are registered from occupancy; both reflect an edge's push/pop after that edge.
REQ-021 FSM states: IDLE, SEND.
REQ-022 req_valid = 1 only in IDLE with FIFO non-empty; req_dest = head dest, combinational from head.
REQ-023 IDLE with grant && req_valid at edge N: pop head, latch descriptor and departure time = counter at edge N, enter SEND.
REQ-024 Grant in SEND, or with req_valid=0, is ignored.
REQ-025 SEND emits one word per cycle with no backpressure; word 0 has data_valid=1 in cycle N+1.
REQ-026 Word count W = max(len>>2, 6); len[1:0] ignored; len < 24 is treated as 24; the header word still carries the original len.
REQ-027 Word 0 = {len,8'b0,dest,8'b0}.
REQ-028 Word 1 = 0; word 2 = {16'b0, SRC_PORT, 8'b0}; word 3 = 0.
REQ-029 Word 4 = start_time; word 5 = departure time.
REQ-030 Payload word k (k=0..W-7) = {SRC_PORT, seq[7:0], k[15:0]}.
REQ-031 data_last = 1 on word W-1 only; SEND -> IDLE after it.
REQ-032 A new grant is accepted at the edge ending the last-word cycle at the earliest, giving back-to-back packets with no gap.
REQ-033 seq is an 8-bit packet counter, incremented once per packet at its last word, wrapping 255 -> 0; first packet after reset uses seq 0.
REQ-034 When data_valid=0, data_out = 0.
REQ-035 FIFO read/write pointers wrap modulo DESC_DEPTH.

Reset
REQ-036 Reset asserted clears outputs at once, including mid-packet: data_out=0, data_valid=0, data_last=0, req_valid=0, buffer_empty=1, buffer_full=0, drop_count=0.
REQ-037 Reset asserted also sets state=IDLE, seq=0, and clears the FIFO pointers.
REQ-038 After reset deasserts, the first write is accepted on the next rising edge.

Verification
REQ-039 Write 0x28000200 at counter=5, grant at counter=12 -> 10 words, no gaps: 0x28000200, 0, 0x00000100, 0, 5, 12, 0x01000000, 0x01000001, 0x01000002, 0x01000003; data_last only on the last.
REQ-040 Write len=8 descriptor, grant -> 6 header-only words (word0 len field=8); data_last on word 5; no payload.
REQ-041 17 writes without grant -> buffer_full after 16th; 17th dropped; drop_count=1; next grant drains exactly 16 packets in order.
REQ-042 FIFO full; write_en and grant in the same cycle -> write accepted, drop_count unchanged, buffer_full stays 1.
REQ-043 Two queued packets, grant held high -> second packet's word 0 directly follows first's data_last; seq fields 0 then 1.
REQ-044 Assert reset during word 3 of a packet -> data_valid=0 immediately; after release, buffer_empty=1 and req_valid=0.

Source files
------------

// File: rtl/ingress.sv
// ingress: descriptor FIFO feeding a packet generator that expands each
// granted descriptor into a gap-free header/payload word stream.
module ingress #(
    parameter int unsigned PACKET_XFER_LEN = 32,
    parameter int unsigned DESC_DEPTH      = 16,
    parameter logic [7:0]  SRC_PORT        = 8'd1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_en,
    input  logic [PACKET_XFER_LEN-1:0] data_in,
    input  logic [31:0]                counter,
    input  logic                       grant,
    output logic                       req_valid,
    output logic [7:0]                 req_dest,
    output logic [PACKET_XFER_LEN-1:0] data_out,
    output logic                       data_valid,
    output logic                       data_last,
    output logic                       buffer_empty,
    output logic                       buffer_full,
    output logic [15:0]                drop_count
);

    localparam int unsigned DW        = PACKET_XFER_LEN;
    localparam int unsigned PTR_W     = $clog2(DESC_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned IDX_W     = 8;
    localparam int unsigned HDR_WORDS = 6;

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic [7:0]  len;
        logic [7:0]  dest;
        logic [31:0] start;
    } desc_t;

    // descriptor storage and status
    desc_t            mem_q [DESC_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, full_q;
    logic [15:0]      drop_q, drop_d;
    desc_t            head_c, wdesc_c;
    logic             push_c, pop_c;
    logic             unused_data;

    // packet generator state
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, nwords_q, nwords_d;
    logic [7:0]       len_q, len_d, dest_q, dest_d, seq_q, seq_d;
    logic [31:0]      start_q, start_d, depart_q, depart_d;
    logic [DW-1:0]    data_q, data_d;
    logic             valid_q, valid_d, last_q, last_d;

    // word idx of the packet described by the latched descriptor fields
    function automatic logic [31:0] build_word(
        input logic [IDX_W-1:0] idx,
        input logic [7:0]       len,
        input logic [7:0]       dest,
        input logic [7:0]       seq,
        input logic [31:0]      start,
        input logic [31:0]      depart
    );
        logic [31:0] w;
        case (idx)
            8'd0:    w = {len, 8'h00, dest, 8'h00};
            8'd1:    w = 32'h0;
            8'd2:    w = {16'h0000, SRC_PORT, 8'h00};
            8'd3:    w = 32'h0;
            8'd4:    w = start;
            8'd5:    w = depart;
            default: w = {SRC_PORT, seq, 8'h00, idx - IDX_W'(HDR_WORDS)};
        endcase
        return w;
    endfunction

    assign head_c      = mem_q[rptr_q];
    assign wdesc_c     = {data_in[31:24], data_in[15:8], counter};
    assign unused_data = ^data_in;

    assign req_valid    = (state_q == IDLE) && !empty_q;
    assign req_dest     = head_c.dest;
    assign pop_c        = req_valid && grant;
    assign push_c       = write_en && (!full_q || pop_c);

    assign data_out     = data_q;
    assign data_valid   = valid_q;
    assign data_last    = last_q;
    assign buffer_empty = empty_q;
    assign buffer_full  = full_q;
    assign drop_count   = drop_q;

    // FIFO pointer, occupancy and drop-counter next state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        if (push_c) wptr_d = wptr_q + PTR_W'(1);
        if (pop_c)  rptr_d = rptr_q + PTR_W'(1);
        if (push_c && !pop_c)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop_c && !push_c) cnt_d = cnt_q - CNT_W'(1);
        if (write_en && !push_c && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    // descriptor array write port; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wptr_q] <= wdesc_c;
    end

    // FIFO control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CNT_W'(DESC_DEPTH));
            drop_q  <= drop_d;
        end
    end

    // packet FSM: IDLE is re-entered while the last word is on the bus so a
    // grant at the end of that cycle starts the next packet without a gap
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nwords_d = nwords_q;
        len_d    = len_q;
        dest_d   = dest_q;
        start_d  = start_q;
        depart_d = depart_q;
        seq_d    = seq_q;
        data_d   = '0;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop_c) begin
                    len_d    = head_c.len;
                    dest_d   = head_c.dest;
                    start_d  = head_c.start;
                    depart_d = counter;
                    nwords_d = (head_c.len[7:2] < 6'd6) ? IDX_W'(HDR_WORDS)
                                                        : IDX_W'(head_c.len[7:2]);
                    data_d   = DW'({head_c.len, 8'h00, head_c.dest, 8'h00});
                    valid_d  = 1'b1;
                    idx_d    = IDX_W'(1);
                    state_d  = SEND;
                end
            end
            SEND: begin
                data_d  = DW'(build_word(idx_q, len_q, dest_q, seq_q, start_q, depart_q));
                valid_d = 1'b1;
                if (idx_q == nwords_q - IDX_W'(1)) begin
                    last_d  = 1'b1;
                    seq_d   = seq_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // packet FSM and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            nwords_q <= '0;
            len_q    <= '0;
            dest_q   <= '0;
            start_q  <= '0;
            depart_q <= '0;
            seq_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nwords_q <= nwords_d;
            len_q    <= len_d;
            dest_q   <= dest_d;
            start_q  <= start_d;
            depart_q <= depart_d;
            seq_q    <= seq_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_ingress.sv
// tb_ingress: directed scenarios plus random traffic, every output compared
// each cycle against a queue-based packet model.
module tb_ingress;

    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  SRC   = 8'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic [31:0] data_in;
    logic [31:0] counter;
    logic        grant;
    logic        req_valid;
    logic [7:0]  req_dest;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_last;
    logic        buffer_empty;
    logic        buffer_full;
    logic [15:0] drop_count;

    int asserts = 0;
    int errors  = 0;

    ingress #(.PACKET_XFER_LEN(32), .DESC_DEPTH(DEPTH), .SRC_PORT(SRC)) dut (
        .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
        .counter(counter), .grant(grant), .req_valid(req_valid), .req_dest(req_dest),
        .data_out(data_out), .data_valid(data_valid), .data_last(data_last),
        .buffer_empty(buffer_empty), .buffer_full(buffer_full), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: pending descriptors, and the remaining words of the current packet
    typedef struct packed {
        logic [7:0]  len;
        logic [7:0]  dest;
        logic [31:0] start;
    } mdesc_t;

    mdesc_t      m_desc[$];
    logic [32:0] m_pend[$];
    logic        m_valid = 1'b0;
    logic        m_last  = 1'b0;
    logic [31:0] m_word  = '0;
    int          m_seq   = 0;
    int          m_drops = 0;
    logic [32:0] mlog[$];
    time         mtime[$];

    mdesc_t      m_h, m_n;
    bit          m_idle, m_popk, m_pushk;
    int          m_nw;
    logic [31:0] m_w;
    logic [32:0] m_e;

    // model update at every active edge from the inputs seen at that edge
    always @(posedge clk) begin
        if (reset) begin
            m_desc.delete();
            m_pend.delete();
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_word  = '0;
            m_seq   = 0;
            m_drops = 0;
        end else begin
            m_idle  = (m_pend.size() == 0);
            m_popk  = grant && m_idle && (m_desc.size() > 0);
            m_pushk = write_en && ((m_desc.size() < DEPTH) || m_popk);
            if (m_popk) begin
                m_h  = m_desc.pop_front();
                m_nw = int'(m_h.len) / 4;
                if (m_nw < 6) m_nw = 6;
                for (int i = 0; i < m_nw; i++) begin
                    case (i)
                        0: m_w = (32'(m_h.len) << 24) | (32'(m_h.dest) << 8);
                        2: m_w = 32'(SRC) << 8;
                        4: m_w = m_h.start;
                        5: m_w = counter;
                        1, 3: m_w = 32'h0;
                        default: m_w = (32'(SRC) << 24) | (32'(m_seq) << 16) | 32'(i - 6);
                    endcase
                    m_pend.push_back({(i == m_nw - 1), m_w});
                end
                m_seq = (m_seq + 1) % 256;
            end
            if (m_pushk) begin
                m_n.len   = data_in[31:24];
                m_n.dest  = data_in[15:8];
                m_n.start = counter;
                m_desc.push_back(m_n);
            end else if (write_en && m_drops < 65535) begin
                m_drops++;
            end
            if (m_pend.size() > 0) begin
                m_e     = m_pend.pop_front();
                m_valid = 1'b1;
                m_last  = m_e[32];
                m_word  = m_e[31:0];
            end else begin
                m_valid = 1'b0;
                m_last  = 1'b0;
                m_word  = '0;
            end
        end
    end

    // compare DUT outputs against the model once per cycle, away from the edge
    always @(negedge clk) begin
        #1;
        if (reset) begin
            chk("rst_valid", 32'(data_valid), 32'h0);
            chk("rst_data",  data_out, 32'h0);
            chk("rst_last",  32'(data_last), 32'h0);
            chk("rst_reqv",  32'(req_valid), 32'h0);
            chk("rst_empty", 32'(buffer_empty), 32'h1);
            chk("rst_full",  32'(buffer_full), 32'h0);
            chk("rst_drops", 32'(drop_count), 32'h0);
        end else begin
            chk("data_valid", 32'(data_valid), 32'(m_valid));
            chk("data_out",   data_out, m_word);
            chk("data_last",  32'(data_last), 32'(m_last));
            chk("req_valid",  32'(req_valid), 32'((m_pend.size() == 0) && (m_desc.size() > 0)));
            if ((m_pend.size() == 0) && (m_desc.size() > 0))
                chk("req_dest", 32'(req_dest), 32'(m_desc[0].dest));
            chk("buffer_empty", 32'(buffer_empty), 32'(m_desc.size() == 0));
            chk("buffer_full",  32'(buffer_full), 32'(m_desc.size() == DEPTH));
            chk("drop_count",   32'(drop_count), 32'(m_drops));
            if (m_valid) begin
                mlog.push_back({m_last, m_word});
                mtime.push_back($time);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        write_en = 1'b0;
        grant    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_desc(input logic [7:0] len, input logic [7:0] dest);
        @(negedge clk);
        write_en = 1'b1;
        data_in  = {len, 8'h00, dest, 8'h00};
        counter  = counter + 1;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        grant = 1'b1;
        while ((m_pend.size() != 0 || m_desc.size() != 0 || m_valid) && n < budget) begin
            @(negedge clk);
            counter = counter + 1;
            n++;
        end
        grant = 1'b0;
        if (n >= budget) begin
            asserts++;
            errors++;
            $display("FAIL %s: drain not finished after %0d cycles", nm, budget);
        end
    endtask

    logic [31:0] exp39 [10] = '{32'h28000200, 32'h0, 32'h00000100, 32'h0, 32'd5, 32'd12,
                                32'h01000000, 32'h01000001, 32'h01000002, 32'h01000003};

    initial begin
        int pk;
        bit sop;
        reset = 1'b1; write_en = 1'b0; grant = 1'b0; data_in = '0; counter = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // single 40-byte packet, written at time 5, granted at time 12
        @(negedge clk); write_en = 1'b1; data_in = 32'h28000200; counter = 32'd5;
        @(negedge clk); write_en = 1'b0; counter = 32'd6;
        @(negedge clk); counter = 32'd7;
        mlog.delete();
        @(negedge clk); grant = 1'b1; counter = 32'd12;
        @(negedge clk); grant = 1'b0; counter = 32'd13;
        repeat (12) @(negedge clk);
        #2;
        chk("r39_count", 32'(mlog.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < mlog.size()) begin
                chk("r39_word", mlog[i][31:0], exp39[i]);
                chk("r39_last", 32'(mlog[i][32]), 32'(i == 9));
            end
        end

        // short descriptor pads to the six header words
        mlog.delete();
        write_desc(8'd8, 8'h03);
        @(negedge clk); write_en = 1'b0; grant = 1'b1;
        @(negedge clk); grant = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        chk("r40_count", 32'(mlog.size()), 32'd6);
        if (mlog.size() == 6) begin
            chk("r40_word0", mlog[0][31:0], 32'h08000300);
            for (int i = 0; i < 6; i++) chk("r40_last", 32'(mlog[i][32]), 32'(i == 5));
        end

        // back-to-back packets after a fresh reset: seq 0 then 1, no gap
        do_reset();
        write_desc(8'd28, 8'h05);
        write_desc(8'd28, 8'h06);
        @(negedge clk); write_en = 1'b0;
        mlog.delete(); mtime.delete();
        grant = 1'b1;
        repeat (17) @(negedge clk);
        grant = 1'b0;
        #2;
        chk("r43_count", 32'(mlog.size()), 32'd14);
        if (mlog.size() == 14) begin
            chk("r43_pay0",  mlog[6][31:0], 32'h01000000);
            chk("r43_last0", 32'(mlog[6][32]), 32'h1);
            chk("r43_hdr1",  mlog[7][31:0], 32'h1C000600);
            chk("r43_gap",   32'(mtime[7] - mtime[6]), 32'd10);
            chk("r43_pay1",  mlog[13][31:0], 32'h01010000);
            chk("r43_last1", 32'(mlog[13][32]), 32'h1);
        end

        // overfill: sixteen stored, seventeenth dropped, drained in order
        for (int i = 0; i < 17; i++) write_desc(8'd24, 8'(i));
        @(negedge clk); write_en = 1'b0;
        #2;
        chk("r41_drops", 32'(drop_count), 32'd1);
        chk("r41_full",  32'(buffer_full), 32'd1);
        mlog.delete();
        drain("r41_drain", 500);
        #2;
        pk = 0; sop = 1'b1;
        foreach (mlog[i]) begin
            if (sop) begin
                chk("r41_order", 32'(mlog[i][15:8]), 32'(pk));
                pk++;
            end
            sop = mlog[i][32];
        end
        chk("r41_pkts", 32'(pk), 32'd16);

        // write against a full FIFO in the same cycle as a grant is accepted
        for (int i = 0; i < 16; i++) write_desc(8'd24, 8'(32 + i));
        @(negedge clk); write_en = 1'b1; grant = 1'b1; data_in = 32'h18006300;
        @(negedge clk); write_en = 1'b0; grant = 1'b0;
        #2;
        chk("r42_drops", 32'(drop_count), 32'd1);
        chk("r42_full",  32'(buffer_full), 32'd1);
        drain("r42_drain", 500);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            counter  = counter + 1;
            write_en = ($urandom_range(0, 2) == 0);
            data_in  = {8'($urandom_range(0, 100)), 8'($urandom), 8'($urandom), 8'($urandom)};
            grant    = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk); write_en = 1'b0;
        drain("rand_drain", 20000);

        // reset in the middle of a packet
        do_reset();
        write_desc(8'd40, 8'h07);
        @(negedge clk); write_en = 1'b0; grant = 1'b1;
        @(negedge clk); grant = 1'b0;
        repeat (3) @(negedge clk);
        chk("r44_word3_valid", 32'(data_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("r44_valid_now", 32'(data_valid), 32'h0);
        chk("r44_data_now",  data_out, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        chk("r44_empty", 32'(buffer_empty), 32'h1);
        chk("r44_reqv",  32'(req_valid), 32'h0);

        repeat (3) @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", errors);
        $fatal(1, "watchdog");
    end

endmodule
